// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the front-end decode blocks:
// opcode/funct encodings, bubble word and exception vector addresses.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] ILLOP    = 32'h8000_0004;
  localparam logic [31:0] XADR     = 32'h8000_0008;

  // How the IF/ID register advances on the next edge.
  typedef enum logic [1:0] {
    UPD_LOAD,
    UPD_HOLD,
    UPD_FLUSH,
    UPD_KILL
  } id_update_e;

endpackage

// File: rtl/id_legal_decode.sv
// Combinational decode of the ID word: immediate/register jump detect
// and undefined-instruction detect over the supported MIPS subset.
module id_legal_decode
  import mips_isa_pkg::*;
(
  input  logic [31:0] instr,
  output logic        jump_i,
  output logic        jump_r,
  output logic        undefined
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       op_legal;
  logic       funct_legal;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    op_legal    = 1'b0;
    funct_legal = 1'b0;
    if ((op <= OP_ORI) || (op == OP_LUI) || (op == OP_LW) || (op == OP_SW))
      op_legal = 1'b1;
    if ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA) ||
        (funct == FN_JR) || (funct == FN_JALR) ||
        ((funct >= FN_ADD) && (funct <= FN_NOR)) ||
        (funct == FN_SLT) || (funct == FN_SLTU))
      funct_legal = 1'b1;
  end

  assign jump_i    = (op == OP_J) || (op == OP_JAL);
  assign jump_r    = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
  assign undefined = !op_legal || ((op == OP_RTYPE) && !funct_legal);

endmodule

// File: rtl/id_redirect_unit.sv
// IF/ID pipeline register plus jump / exception / interrupt redirect
// requests back to the fetch stage's next-PC mux.
module id_redirect_unit #(
  parameter bit          IRQ_ENABLE = 1'b1,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_Instruction,
  input  logic        Loaduse,
  input  logic        EX_Branch_EN,
  input  logic        irq_in,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC_Plus_4,
  output logic [31:0] ID_Instruction,
  output logic        ID_Valid,
  output logic        ID_Jump_I,
  output logic [31:0] ID_JT,
  output logic        ID_Jump_R,
  output logic        ID_EXP,
  output logic        ID_IRQ,
  output logic        ID_Save_EN,
  output logic [31:0] ID_Save_PC
);

  import mips_isa_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        irq_pend_q;
  logic        irq_pend_d;

  logic        dec_jump_i;
  logic        dec_jump_r;
  logic        dec_undefined;
  logic        kernel;
  logic        gate;
  logic        irq_take;
  logic        exp_take;
  logic        jump_i_take;
  logic        jump_r_take;
  logic        redirect;
  logic        kernel_kill;
  logic [31:0] pc_plus_4;
  id_update_e  upd;

  id_legal_decode u_decode (
    .instr     (instr_q),
    .jump_i    (dec_jump_i),
    .jump_r    (dec_jump_r),
    .undefined (dec_undefined)
  );

  assign pc_plus_4 = pc_q + 32'd4;
  assign kernel    = pc_q[31];
  assign gate      = valid_q && !Loaduse && !EX_Branch_EN;

  // Priority chain keeps the four requests mutually exclusive: IRQ > EXP > jumps.
  assign irq_take    = IRQ_ENABLE && irq_pend_q && !kernel && gate;
  assign exp_take    = dec_undefined && !kernel && gate && !irq_take;
  assign jump_i_take = dec_jump_i && gate && !irq_take && !exp_take;
  assign jump_r_take = dec_jump_r && gate && !irq_take && !exp_take;
  assign redirect    = EX_Branch_EN || irq_take || exp_take || jump_i_take || jump_r_take;

  // Kernel code never traps on an undefined word; it is silently bubbled instead.
  assign kernel_kill = valid_q && kernel && dec_undefined;

  always_comb begin
    upd = UPD_LOAD;
    if (redirect)
      upd = UPD_FLUSH;
    else if (Loaduse)
      upd = UPD_HOLD;
    else if (kernel_kill)
      upd = UPD_KILL;
  end

  always_comb begin
    irq_pend_d = irq_pend_q;
    if (!IRQ_ENABLE)
      irq_pend_d = 1'b0;
    else if (irq_in)
      irq_pend_d = 1'b1;
    else if (irq_take)
      irq_pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
      case (upd)
        UPD_FLUSH: begin
          pc_q    <= IF_PC;
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
        end
        UPD_KILL: begin
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
        end
        UPD_LOAD: begin
          pc_q    <= IF_PC;
          instr_q <= IF_Instruction;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ID_PC          = pc_q;
  assign ID_PC_Plus_4   = pc_plus_4;
  assign ID_Instruction = instr_q;
  assign ID_Valid       = valid_q;
  assign ID_JT          = {pc_plus_4[31:28], instr_q[25:0], 2'b00};
  assign ID_Jump_I      = jump_i_take;
  assign ID_Jump_R      = jump_r_take;
  assign ID_EXP         = exp_take;
  assign ID_IRQ         = irq_take;
  assign ID_Save_EN     = irq_take || exp_take;
  assign ID_Save_PC     = irq_take ? pc_q : (exp_take ? pc_plus_4 : '0);

endmodule

// File: tb/tb_id_redirect_unit.sv
// Directed bench for id_redirect_unit: each step drives the IF-side inputs,
// queues the expected ID-side picture and checks it before the next edge.
module tb_id_redirect_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instruction;
  logic        Loaduse;
  logic        EX_Branch_EN;
  logic        irq_in;
  logic [31:0] ID_PC;
  logic [31:0] ID_PC_Plus_4;
  logic [31:0] ID_Instruction;
  logic        ID_Valid;
  logic        ID_Jump_I;
  logic [31:0] ID_JT;
  logic        ID_Jump_R;
  logic        ID_EXP;
  logic        ID_IRQ;
  logic        ID_Save_EN;
  logic [31:0] ID_Save_PC;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        chk_pc;
    logic [31:0] instr;
    logic        valid;
    logic [3:0]  req;      // {irq, exp, jump_i, jump_r}
    logic [31:0] save_pc;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] W_A  = 32'h2008_0001;
  localparam logic [31:0] W_B  = 32'h0000_0020;
  localparam logic [31:0] W_C  = 32'h8C01_0000;
  localparam logic [31:0] W_J  = 32'h0800_0010;
  localparam logic [31:0] W_X  = 32'h2401_0000;
  localparam logic [31:0] W_JR = 32'h03E0_0008;
  localparam logic [31:0] W_D  = 32'h2002_0002;
  localparam logic [31:0] W_U  = 32'hFC00_0000;
  localparam logic [31:0] W_E  = 32'h2003_0003;
  localparam logic [31:0] W_K  = 32'h2004_0004;
  localparam logic [31:0] W_K2 = 32'h2005_0005;
  localparam logic [31:0] W_F  = 32'h2006_0006;
  localparam logic [31:0] W_G  = 32'h2007_0007;
  localparam logic [31:0] W_H  = 32'h2008_0008;
  localparam logic [31:0] W_F2 = 32'h2009_0009;

  id_redirect_unit #(
    .IRQ_ENABLE (1'b1),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .IF_PC          (IF_PC),
    .IF_Instruction (IF_Instruction),
    .Loaduse        (Loaduse),
    .EX_Branch_EN   (EX_Branch_EN),
    .irq_in         (irq_in),
    .ID_PC          (ID_PC),
    .ID_PC_Plus_4   (ID_PC_Plus_4),
    .ID_Instruction (ID_Instruction),
    .ID_Valid       (ID_Valid),
    .ID_Jump_I      (ID_Jump_I),
    .ID_JT          (ID_JT),
    .ID_Jump_R      (ID_Jump_R),
    .ID_EXP         (ID_EXP),
    .ID_IRQ         (ID_IRQ),
    .ID_Save_EN     (ID_Save_EN),
    .ID_Save_PC     (ID_Save_PC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int step, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic chk_pc, input logic [31:0] instr,
                              input logic valid, input logic [3:0] req, input logic [31:0] save_pc);
    exp_t e;
    e.pc = pc; e.chk_pc = chk_pc; e.instr = instr; e.valid = valid; e.req = req; e.save_pc = save_pc;
    return e;
  endfunction

  task automatic check_front(input int step);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", step, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (e.chk_pc) chk("id_pc", step, ID_PC, e.pc);
      chk("id_instr",   step, ID_Instruction, e.instr);
      chk("id_valid",   step, {31'd0, ID_Valid}, {31'd0, e.valid});
      chk("requests",   step, {28'd0, ID_IRQ, ID_EXP, ID_Jump_I, ID_Jump_R}, {28'd0, e.req});
      chk("save_en",    step, {31'd0, ID_Save_EN}, {31'd0, (e.req[3] | e.req[2])});
      chk("save_pc",    step, ID_Save_PC, e.save_pc);
    end
  endtask

  // Drive one cycle of fetch-side inputs, check the ID picture, then advance to the next negedge.
  task automatic drive(input int step, input logic [31:0] pc, input logic [31:0] instr,
                       input logic lu, input logic br, input logic irq, input exp_t e);
    IF_PC          = pc;
    IF_Instruction = instr;
    Loaduse        = lu;
    EX_Branch_EN   = br;
    irq_in         = irq;
    sb.push_back(e);
    #1;
    check_front(step);
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    IF_PC          = '0;
    IF_Instruction = '0;
    Loaduse        = 1'b0;
    EX_Branch_EN   = 1'b0;
    irq_in         = 1'b0;

    #2;
    chk("rst_pc",      0, ID_PC, 32'h0);
    chk("rst_instr",   0, ID_Instruction, 32'h0);
    chk("rst_valid",   0, {31'd0, ID_Valid}, 32'd0);
    chk("rst_req",     0, {27'd0, ID_IRQ, ID_EXP, ID_Jump_I, ID_Jump_R, ID_Save_EN}, 32'd0);
    chk("rst_plus4",   0, ID_PC_Plus_4, 32'h4);
    chk("rst_jt",      0, ID_JT, 32'h0);
    chk("rst_save_pc", 0, ID_Save_PC, 32'h0);

    @(negedge clk);
    reset = 1'b0;

    // Straight-line fetch
    drive(1,  32'h0000_0000, W_A,  0, 0, 0, mk(32'h0,   1, 32'h0, 0, 4'b0000, 32'h0));
    drive(2,  32'h0000_0004, W_B,  0, 0, 0, mk(32'h0,   1, W_A,   1, 4'b0000, 32'h0));
    drive(3,  32'h0000_0008, W_C,  0, 0, 0, mk(32'h4,   1, W_B,   1, 4'b0000, 32'h0));
    drive(4,  32'h0000_0020, W_J,  0, 0, 0, mk(32'h8,   1, W_C,   1, 4'b0000, 32'h0));
    // Immediate jump in ID
    IF_PC = 32'h0000_0024; IF_Instruction = W_X; sb.push_back(mk(32'h20, 1, W_J, 1, 4'b0010, 32'h0));
    #1;
    check_front(5);
    chk("jump_target", 5, ID_JT, 32'h0000_0040);
    chk("pc_plus_4",   5, ID_PC_Plus_4, 32'h0000_0024);
    @(negedge clk);
    drive(6,  32'h0000_0040, W_JR, 0, 0, 0, mk(32'h24,  1, 32'h0, 0, 4'b0000, 32'h0));
    // Register jump held off by a two-cycle load-use stall
    drive(7,  32'h0000_0044, W_D,  1, 0, 0, mk(32'h40,  1, W_JR,  1, 4'b0000, 32'h0));
    drive(8,  32'h0000_0044, W_D,  1, 0, 0, mk(32'h40,  1, W_JR,  1, 4'b0000, 32'h0));
    drive(9,  32'h0000_0044, W_D,  0, 0, 0, mk(32'h40,  1, W_JR,  1, 4'b0001, 32'h0));
    // Undefined word in user mode traps
    drive(10, 32'h0000_0100, W_U,  0, 0, 0, mk(32'h44,  1, 32'h0, 0, 4'b0000, 32'h0));
    drive(11, 32'h0000_0104, W_E,  0, 0, 0, mk(32'h100, 1, W_U,   1, 4'b0100, 32'h104));
    // Same word in kernel mode: no trap, bubbled in place
    drive(12, 32'h8000_0100, W_U,  0, 0, 0, mk(32'h104, 1, 32'h0, 0, 4'b0000, 32'h0));
    drive(13, 32'h8000_0104, W_K,  0, 0, 0, mk(32'h8000_0100, 1, W_U, 1, 4'b0000, 32'h0));
    drive(14, 32'h8000_0010, W_K2, 0, 0, 0, mk(32'h0,   0, 32'h0, 0, 4'b0000, 32'h0));
    // IRQ pulse while in kernel stays pending until user code reaches ID
    drive(15, 32'h0000_0200, W_F,  0, 0, 1, mk(32'h8000_0010, 1, W_K2, 1, 4'b0000, 32'h0));
    drive(16, 32'h0000_0204, W_G,  0, 0, 0, mk(32'h200, 1, W_F,   1, 4'b1000, 32'h200));
    drive(17, 32'h0000_0200, W_F,  0, 0, 0, mk(32'h204, 1, 32'h0, 0, 4'b0000, 32'h0));
    drive(18, 32'h0000_0204, W_G,  0, 0, 1, mk(32'h200, 1, W_F,   1, 4'b0000, 32'h0));
    // Branch beats a pending IRQ; the IRQ is taken on the next valid user word
    drive(19, 32'h0000_0208, W_H,  0, 1, 0, mk(32'h204, 1, W_G,   1, 4'b0000, 32'h0));
    drive(20, 32'h0000_0300, W_F2, 0, 0, 0, mk(32'h208, 1, 32'h0, 0, 4'b0000, 32'h0));
    drive(21, 32'h0000_0304, W_G,  0, 0, 0, mk(32'h300, 1, W_F2,  1, 4'b1000, 32'h300));
    drive(22, 32'h0000_0300, W_F2, 0, 0, 0, mk(32'h304, 1, 32'h0, 0, 4'b0000, 32'h0));
    drive(23, 32'h0000_0304, W_G,  0, 0, 0, mk(32'h300, 1, W_F2,  1, 4'b0000, 32'h0));

    // Asynchronous reset away from any clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 24, {31'd0, ID_Valid}, 32'd0);
    chk("async_rst_pc",    24, ID_PC, 32'h0);
    chk("async_rst_instr", 24, ID_Instruction, 32'h0);

    chk("scoreboard_drained", 24, sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/id_redirect_unit.md
# id_redirect_unit

IF/ID pipeline register and front-end redirect source for the 5-stage MIPS pipeline. It captures the fetched PC/instruction from the fetch stage and decodes `j`/`jal`/`jr`/`jalr`, undefined instructions and pending interrupts. It drives the jump, exception and interrupt requests back into the fetch stage's next-PC mux, and squashes wrong-path instructions on branches, jumps, exceptions and interrupts.

## Interface
- `IRQ_ENABLE`, default 1: 0 ties `ID_IRQ` low and ignores `irq_in`.
- `NOP_WORD`, default 32'h0000_0000: instruction word inserted as a bubble.
- `clk` in 1: system clock; all state updates on the posedge.
- `reset` in 1: asynchronous, active-high.
- `IF_PC` in 32: PC of the instruction currently in fetch.
- `IF_Instruction` in 32: fetched word.
- `Loaduse` in 1: hazard stall; the ID register holds.
- `EX_Branch_EN` in 1: taken branch resolved in EX; the ID content is wrong-path.
- `irq_in` in 1: level interrupt request from the timer/peripherals.
- `ID_PC`, `ID_PC_Plus_4` out 32: registered PC and PC+4.
- `ID_Instruction` out 32: registered word (`NOP_WORD` when bubbled).
- `ID_Valid` out 1: the ID slot holds a real instruction.
- `ID_Jump_I` out 1, `ID_JT` out 32: immediate jump request and its target.
- `ID_Jump_R` out 1: register jump request; the target comes from the register file.
- `ID_EXP` out 1: undefined-instruction exception request.
- `ID_IRQ` out 1: interrupt-taken request.
- `ID_Save_EN` out 1, `ID_Save_PC` out 32: return-address capture for `$k0`.

## Operation
- Decode fields: `op` = instr[31:26], `funct` = instr[5:0].
- `ID_JT` = {ID_PC_Plus_4[31:28], instr[25:0], 2'b00}.
  - The combinational value is always driven.
  - `ID_PC_Plus_4` = ID_PC + 4, modulo 2^32.
- `Jump_I` raw: `op` is 0x02 or 0x03.
- `Jump_R` raw: `op` is 0x00 and `funct` is 0x08 or 0x09.
- Legal opcodes: 0x00–0x0D and 0x0F, 0x23, 0x2B.
  - For `op` 0x00, legal functs are 0x00, 0x02, 0x03, 0x08, 0x09, 0x20–0x27, 0x2A, 0x2B.
  - Anything else is undefined.
- `kernel` = ID_PC[31].
- `gate` = ID_Valid & ~Loaduse & ~EX_Branch_EN.
- Request outputs, mutually exclusive, in this priority:
  - `ID_IRQ` = IRQ_ENABLE & irq_pend & ~kernel & gate.
  - `ID_EXP` = undefined & ~kernel & gate & ~ID_IRQ.
  - `ID_Jump_I` and `ID_Jump_R` = raw decode & gate & ~ID_IRQ & ~ID_EXP.
- Undefined instruction in kernel mode:
  - No `ID_EXP` is raised.
  - Next cycle the instruction is replaced in place by a bubble, unless stalled.
- `ID_Save_EN` = ID_IRQ | ID_EXP.
  - On `ID_IRQ`, `ID_Save_PC` = ID_PC; the interrupted instruction re-executes.
  - On `ID_EXP`, `ID_Save_PC` = ID_PC_Plus_4.
- `irq_pend` register:
  - Set when `irq_in` is 1.
  - Cleared on a cycle with `ID_IRQ`=1, unless `irq_in` is still 1.
- IF/ID register update, first match wins:
  1. `EX_Branch_EN`, `ID_IRQ`, `ID_EXP`, `ID_Jump_I` or `ID_Jump_R` is 1: load a bubble (`NOP_WORD`, `ID_Valid`=0, `ID_PC` = IF_PC). No delay slot.
  2. `Loaduse` is 1: hold all registers.
  3. Otherwise: load `IF_PC` and `IF_Instruction` with `ID_Valid`=1.

## Timing
- Reset values: `ID_PC`=0, `ID_Instruction`=NOP_WORD, `ID_Valid`=0, `irq_pend`=0.
  - All request outputs are 0 during reset.
  - `ID_Save_PC`=0, `ID_JT`=0, `ID_PC_Plus_4`=4.
- Reset asserted mid-operation clears state immediately, regardless of `clk`.
- Fetch-to-ID latency is 1 cycle.
- Redirect outputs are combinational from ID registers and inputs. Fetch consumes them in the same cycle.
- Flush takes effect at the next edge.
- Branch and IRQ in the same cycle: the branch wins. `ID_IRQ` is suppressed, the pending bit persists, and the IRQ is taken on the next valid user-mode instruction.
- `Loaduse` together with a jump in ID: the jump is suppressed and the register holds. The jump fires the cycle `Loaduse` drops.
- `irq_in` pulse while in kernel mode: it stays pending until the first valid user-mode instruction reaches ID.

## Structure
- Shared package `mips_isa_pkg`: opcode and funct constants, `NOP_WORD`, ILLOP and XADR addresses.
- Sub-module `id_legal_decode`: combinational; instr in, jump_i / jump_r / undefined out.
- The top level contains the pipeline register, `irq_pend` and the request gating.

## Test plan
- Reset, then straight-line words at PC 0, 4, 8 with no hazards: each word appears in ID one cycle later, `ID_Valid`=1, no requests asserted.
- `j` 0x08000010 with ID_PC=0x00000020: `ID_Jump_I`=1 and `ID_JT`=0x00000040. Next cycle `ID_Valid`=0 and `ID_Instruction`=0.
- `jr` held with `Loaduse`=1 for 2 cycles: `ID_Jump_R` stays 0 and the register holds. The cycle after `Loaduse` drops, `ID_Jump_R`=1.
- Word 0xFC000000 at ID_PC=0x100: `ID_EXP`=1 and `ID_Save_PC`=0x104.
  - Same word at ID_PC=0x80000100: no `ID_EXP`, and the slot is bubbled next cycle.
- `irq_in` pulse for 1 cycle while ID_PC=0x80000010, then a user instruction at 0x200: `ID_IRQ`=1 at 0x200, `ID_Save_PC`=0x200, `irq_pend` cleared.
- `irq_pend`=1 and `EX_Branch_EN`=1 in the same cycle: `ID_IRQ`=0 and ID is bubbled. The IRQ is taken on the next valid user instruction.
